// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store controller.
//   - memop encodings as seen on req_memop / mem_memop
//   - response error codes as seen on rsp_err
//   - FSM state type of lsu_ctrl
package lsu_pkg;

  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_MEMOP    = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCap,
    StWr,
    StResp
  } lsu_state_t;

endpackage

// File: rtl/lsu_check.sv
// lsu_check: combinational request classifier.
//   we_i    : 1 = store, 0 = load
//   memop_i : access type (lsu_pkg MEMOP_*)
//   addr_i  : byte address
//   err_o   : ERR_NONE, or the highest-priority error (memop > misalign > range)
module lsu_check
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_AW = 17
) (
  input  logic        we_i,
  input  logic [2:0]  memop_i,
  input  logic [31:0] addr_i,
  output logic [1:0]  err_o
);

  logic memop_bad;
  logic misalign;
  logic out_of_range;

  always_comb begin
    memop_bad = 1'b0;
    misalign  = 1'b0;
    case (memop_i)
      MEMOP_LB:  memop_bad = 1'b0;
      MEMOP_LH:  misalign  = addr_i[0];
      MEMOP_LW:  misalign  = |addr_i[1:0];
      MEMOP_LBU: memop_bad = we_i;
      MEMOP_LHU: begin
        memop_bad = we_i;
        misalign  = addr_i[0];
      end
      default:   memop_bad = 1'b1;
    endcase
  end

  // Any address bit at or above MEM_AW lies outside the backed memory.
  assign out_of_range = |(addr_i >> MEM_AW);

  always_comb begin
    if (memop_bad) begin
      err_o = ERR_MEMOP;
    end else if (misalign) begin
      err_o = ERR_MISALIGN;
    end else if (out_of_range) begin
      err_o = ERR_RANGE;
    end else begin
      err_o = ERR_NONE;
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: one-at-a-time load/store controller in front of data_mem.
//   clk_i / rst_ni          : clock, asynchronous active-low reset
//   req_*                   : request channel (valid/ready), we, memop, addr, wdata
//   mem_*_o / mem_dataout_i : registered drive to data_mem, extended read data back
//   rsp_*                   : response channel (valid/ready), rdata, err code
//   ld_cnt_o/st_cnt_o/err_cnt_o : saturating debug counters
// Loads take IDLE->RD->CAP->RESP to cover data_mem's one-cycle read latency,
// stores IDLE->WR->RESP, rejected requests IDLE->RESP.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_AW = 17,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [2:0]       req_memop_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_datain_o,
  output logic [2:0]       mem_memop_o,
  output logic             mem_we_o,
  input  logic [31:0]      mem_dataout_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_rdata_o,
  output logic [1:0]       rsp_err_o,
  output logic [CNT_W-1:0] ld_cnt_o,
  output logic [CNT_W-1:0] st_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  lsu_state_t       state_q, state_d;
  logic [1:0]       chk_err;
  logic             accept;
  logic [31:0]      addr_q, datain_q, rdata_q;
  logic [2:0]       memop_q;
  logic             we_q;
  logic [1:0]       err_q;
  logic [CNT_W-1:0] ld_cnt_q, st_cnt_q, err_cnt_q;

  lsu_check #(
    .MEM_AW (MEM_AW)
  ) u_check (
    .we_i    (req_we_i),
    .memop_i (req_memop_i),
    .addr_i  (req_addr_i),
    .err_o   (chk_err)
  );

  assign accept = req_valid_i & (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (chk_err != ERR_NONE) begin
            state_d = StResp;
          end else if (req_we_i) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:   state_d = StCap;
      StCap:  state_d = StResp;
      StWr:   state_d = StResp;
      StResp: if (rsp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      datain_q  <= '0;
      memop_q   <= '0;
      we_q      <= 1'b0;
      err_q     <= ERR_NONE;
      rdata_q   <= '0;
      ld_cnt_q  <= '0;
      st_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      // Registered from the next state so mem_we has no path from req_* to the pin.
      we_q    <= (state_d == StWr);

      if (accept) begin
        addr_q   <= req_addr_i;
        memop_q  <= req_memop_i;
        datain_q <= req_we_i ? req_wdata_i : '0;
        err_q    <= chk_err;
        rdata_q  <= '0;
        if ((chk_err != ERR_NONE) && !(&err_cnt_q)) begin
          err_cnt_q <= err_cnt_q + 1'b1;
        end
      end

      // data_mem output is valid during CAP; capture it on the way into RESP.
      if (state_q == StCap) begin
        rdata_q <= mem_dataout_i;
        if (!(&ld_cnt_q)) begin
          ld_cnt_q <= ld_cnt_q + 1'b1;
        end
      end

      if ((state_q == StWr) && !(&st_cnt_q)) begin
        st_cnt_q <= st_cnt_q + 1'b1;
      end
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign rsp_valid_o  = (state_q == StResp);
  assign mem_addr_o   = addr_q;
  assign mem_datain_o = datain_q;
  assign mem_memop_o  = memop_q;
  assign mem_we_o     = we_q;
  assign rsp_rdata_o  = rdata_q;
  assign rsp_err_o    = err_q;
  assign ld_cnt_o     = ld_cnt_q;
  assign st_cnt_o     = st_cnt_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: bench for lsu_ctrl with a behavioural data_mem beside it.
// A second instance with 2-bit counters shares all inputs to observe saturation.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int unsigned MemAw = 17;
  localparam int unsigned Words = (2 ** MemAw) / 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_memop;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] mem_addr, mem_datain, mem_dataout;
  logic [2:0]  mem_memop;
  logic        mem_we;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [15:0] ld_cnt, st_cnt, err_cnt;

  logic        s_req_ready, s_mem_we, s_rsp_valid;
  logic [31:0] s_mem_addr, s_mem_datain, s_rsp_rdata;
  logic [2:0]  s_mem_memop;
  logic [1:0]  s_rsp_err;
  logic [1:0]  s_ld_cnt, s_st_cnt, s_err_cnt;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_AW(MemAw), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_memop_i(req_memop), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .mem_addr_o(mem_addr), .mem_datain_o(mem_datain), .mem_memop_o(mem_memop),
    .mem_we_o(mem_we), .mem_dataout_i(mem_dataout),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .ld_cnt_o(ld_cnt), .st_cnt_o(st_cnt), .err_cnt_o(err_cnt)
  );

  lsu_ctrl #(.MEM_AW(MemAw), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(s_req_ready), .req_we_i(req_we),
    .req_memop_i(req_memop), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .mem_addr_o(s_mem_addr), .mem_datain_o(s_mem_datain), .mem_memop_o(s_mem_memop),
    .mem_we_o(s_mem_we), .mem_dataout_i(mem_dataout),
    .rsp_valid_o(s_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(s_rsp_rdata),
    .rsp_err_o(s_rsp_err), .ld_cnt_o(s_ld_cnt), .st_cnt_o(s_st_cnt), .err_cnt_o(s_err_cnt)
  );

  // ---------------- data_mem stand-in: word array, 1-cycle synchronous read
  logic [31:0] dmem [Words];

  function automatic logic [31:0] merge_store(input logic [31:0] w, input logic [1:0] off,
                                              input logic [2:0] op, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (op[1:0])
      2'b00:   r[8*off +: 8] = d[7:0];
      2'b01:   r[16*off[1] +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] w, input logic [1:0] off,
                                               input logic [2:0] op);
    logic [31:0] s;
    s = w >> (8 * off);
    case (op)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'b0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'b0, s[15:0]};
      3'b010:  return w;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      dmem[mem_addr[MemAw-1:2]] <= merge_store(dmem[mem_addr[MemAw-1:2]], mem_addr[1:0],
                                               mem_memop, mem_datain);
    end
    mem_dataout <= extract_load(dmem[mem_addr[MemAw-1:2]], mem_addr[1:0], mem_memop);
  end

  // ---------------- reference model: byte-addressed memory plus counts
  logic [7:0] ref_mem [int unsigned];
  int m_ld, m_st, m_err;
  int n_checks, n_fail;

  function automatic logic [1:0] model_err(input logic we, input logic [2:0] op,
                                           input logic [31:0] addr);
    int unsigned size;
    if (op == 3'b011 || op == 3'b110 || op == 3'b111 || (op[2] && we)) return ERR_MEMOP;
    size = 1 << op[1:0];
    if ((addr % size) != 0) return ERR_MISALIGN;
    if (addr >= 32'h0002_0000) return ERR_RANGE;
    return ERR_NONE;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr);
    int unsigned n;
    logic [31:0] v;
    n = 1 << op[1:0];
    v = 32'h0;
    for (int i = 0; i < int'(n); i++) begin
      if (ref_mem.exists(addr + i)) v = v | (32'(ref_mem[addr + i]) << (8 * i));
    end
    if (!op[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wd);
    int unsigned n;
    n = 1 << op[1:0];
    for (int i = 0; i < int'(n); i++) ref_mem[addr + i] = wd[8*i +: 8];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic check_counters(input string name);
    check({name, " ld_cnt"}, 32'(ld_cnt), 32'(m_ld));
    check({name, " st_cnt"}, 32'(st_cnt), 32'(m_st));
    check({name, " err_cnt"}, 32'(err_cnt), 32'(m_err));
    check({name, " sat ld"}, 32'(s_ld_cnt), 32'(sat3(m_ld)));
    check({name, " sat st"}, 32'(s_st_cnt), 32'(sat3(m_st)));
    check({name, " sat err"}, 32'(s_err_cnt), 32'(sat3(m_err)));
  endtask

  // One full transaction; hold > 0 keeps rsp_ready low that many cycles while a
  // rogue store is offered on the request port.
  task automatic run_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] exp_err,
                         input logic [31:0] exp_rdata, input string name, input int hold);
    int lat, we_cyc, exp_lat, exp_we;
    exp_lat = (exp_err != ERR_NONE) ? 1 : (we ? 2 : 3);
    exp_we  = (exp_err == ERR_NONE && we) ? 1 : 0;
    @(negedge clk);
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    check({name, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_memop = op; req_addr = addr; req_wdata = wd;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom(); req_wdata = $urandom();
    lat = 1;
    we_cyc = int'(mem_we);
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
      we_cyc += int'(mem_we);
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    check({name, " rsp_rdata"}, rsp_rdata, exp_rdata);
    check({name, " mem_we cycles"}, 32'(we_cyc), 32'(exp_we));
    check({name, " mem_addr"}, mem_addr, addr);
    check({name, " mem_memop"}, 32'(mem_memop), 32'(op));
    check({name, " mem_datain"}, mem_datain, we ? wd : 32'h0);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_we = 1'b1; req_memop = MEMOP_LW; req_addr = 32'h44;
      req_wdata = 32'h5555_AAAA;
      @(negedge clk);
      check({name, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({name, " hold rsp_rdata"}, rsp_rdata, exp_rdata);
      check({name, " hold req_ready"}, 32'(req_ready), 32'd0);
      check({name, " hold mem_we"}, 32'(mem_we), 32'd0);
      check({name, " hold mem_addr"}, mem_addr, addr);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({name, " post req_ready"}, 32'(req_ready), 32'd1);
    if (exp_err != ERR_NONE) m_err++;
    else if (we) begin
      m_st++;
      model_store(op, addr, wd);
    end else m_ld++;
    check_counters(name);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd;
    logic [2:0]  op;
    logic        we;
    logic [1:0]  e;

    n_checks = 0; n_fail = 0; m_ld = 0; m_st = 0; m_err = 0;
    req_valid = 1'b0; req_we = 1'b0; req_memop = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    rst_n = 1'b0;

    vecs[0]  = '{1'b1, MEMOP_LW,  32'h10,        32'hDEAD_BEEF, ERR_NONE,     32'h0};
    vecs[1]  = '{1'b0, MEMOP_LW,  32'h10,        32'h0,         ERR_NONE,     32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, MEMOP_LB,  32'h13,        32'h1234_5680, ERR_NONE,     32'h0};
    vecs[3]  = '{1'b0, MEMOP_LB,  32'h13,        32'h0,         ERR_NONE,     32'hFFFF_FF80};
    vecs[4]  = '{1'b0, MEMOP_LBU, 32'h13,        32'h0,         ERR_NONE,     32'h0000_0080};
    vecs[5]  = '{1'b1, MEMOP_LH,  32'h12,        32'h0000_8001, ERR_NONE,     32'h0};
    vecs[6]  = '{1'b0, MEMOP_LHU, 32'h12,        32'h0,         ERR_NONE,     32'h0000_8001};
    vecs[7]  = '{1'b0, MEMOP_LW,  32'h6,         32'h0,         ERR_MISALIGN, 32'h0};
    vecs[8]  = '{1'b1, MEMOP_LW,  32'h0002_0000, 32'h1111_2222, ERR_RANGE,    32'h0};
    vecs[9]  = '{1'b1, MEMOP_LBU, 32'h10,        32'h0000_00AA, ERR_MEMOP,    32'h0};
    vecs[10] = '{1'b0, MEMOP_LH,  32'h0002_0001, 32'h0,         ERR_MISALIGN, 32'h0};
    vecs[11] = '{1'b0, MEMOP_LW,  32'h10,        32'h0,         ERR_NONE,     32'h8001_BEEF};

    #1;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_datain", mem_datain, 32'd0);
    check("reset mem_memop", 32'(mem_memop), 32'd0);
    check_counters("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset release req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_req(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].err, vecs[i].rdata,
              $sformatf("vec%0d", i), 0);
    end
    check("table err_cnt", 32'(err_cnt), 32'd4);
    check("table st_cnt", 32'(st_cnt), 32'd3);
    check("table ld_cnt", 32'(ld_cnt), 32'd5);

    // Backpressure: response held for 10 cycles, rogue request ignored.
    run_req(1'b0, MEMOP_LW, 32'h10, 32'h0, ERR_NONE, 32'h8001_BEEF, "backpressure", 10);

    // Reset during WR.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_memop = MEMOP_LW; req_addr = 32'h40;
    req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstwr mem_we before", 32'(mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstwr mem_we", 32'(mem_we), 32'd0);
    check("rstwr rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstwr req_ready", 32'(req_ready), 32'd1);
    check("rstwr mem_addr", mem_addr, 32'd0);
    check("rstwr mem_datain", mem_datain, 32'd0);
    check("rstwr rsp_err", 32'(rsp_err), 32'd0);
    m_ld = 0; m_st = 0; m_err = 0;
    check_counters("rstwr");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rstwr idle rsp_valid", 32'(rsp_valid), 32'd0);
      check("rstwr idle req_ready", 32'(req_ready), 32'd1);
    end

    // Fill a window so random loads read defined data.
    for (int w = 0; w < 16; w++) begin
      wd = $urandom();
      run_req(1'b1, MEMOP_LW, 32'h100 + 32'(4 * w), wd, ERR_NONE, 32'h0, "fill", 0);
    end

    // Saturation: five loads with 2-bit counters in u_sat.
    for (int l = 0; l < 5; l++) begin
      run_req(1'b0, MEMOP_LW, 32'h104, 32'h0, ERR_NONE, model_load(MEMOP_LW, 32'h104),
              "satload", 0);
    end
    check("sat ld_cnt held", 32'(s_ld_cnt), 32'd3);
    check("full ld_cnt", 32'(ld_cnt), 32'd5);

    for (int r = 0; r < 40; r++) begin
      a  = 32'h100 + ($urandom() % 64);
      if (($urandom() % 8) == 0) a[17 + ($urandom() % 15)] = 1'b1;
      op = 3'($urandom());
      we = 1'($urandom());
      wd = $urandom();
      e  = model_err(we, op, a);
      run_req(we, op, a, wd, e, (e == ERR_NONE && !we) ? model_load(op, a) : 32'h0,
              $sformatf("rand%0d", r), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
